// File: rtl/ex_hazard_ctrl_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Shared forwarding encodings and the EX/MEM/WB shadow stage record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int REC_AW = 5;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_PRE    = 2'b01;
  localparam logic [1:0] FWD_PREPRE = 2'b10;

  localparam logic [REC_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rs;
    logic [REC_AW-1:0] rt;
    logic [REC_AW-1:0] dest;
    logic              regWrite;
    logic              memRead;
  } stageRec_t;

endpackage

`default_nettype wire

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// ============================================================================
// Module : fwd_sel
// Picks one EX operand source from the MEM and WB shadow records.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_sel
  import pipe_pkg::*;
(
  input  logic              srcValid,
  input  logic [REC_AW-1:0] srcReg,
  input  stageRec_t         memRec,
  input  stageRec_t         wbRec,
  output logic [1:0]        sel
);

  logic w_memHit;
  logic w_wbHit;
  logic w_unusedFields;

  // A load in MEM only has its address available, so it never feeds EX.
  assign w_memHit = memRec.valid & memRec.regWrite & ~memRec.memRead &
                    (memRec.dest != REG_ZERO) & (memRec.dest == srcReg);
  assign w_wbHit  = wbRec.valid & wbRec.regWrite &
                    (wbRec.dest != REG_ZERO) & (wbRec.dest == srcReg);

  assign w_unusedFields = ^{memRec.rs, memRec.rt, wbRec.rs, wbRec.rt, wbRec.memRead};

  always_comb begin
    sel = FWD_REG;
    if (srcValid) begin
      if (w_memHit)
        sel = FWD_PRE;
      else if (w_wbHit)
        sel = FWD_PREPRE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
// ============================================================================
// Module : ex_hazard_ctrl
// EX-stage forwarding selects, load-use stall/bubble control, stall counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_uses_rt,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  stageRec_t r_exRec;
  stageRec_t r_memRec;
  stageRec_t r_wbRec;
  logic [CNT_W-1:0] r_stallCount;

  logic [REC_AW-1:0] w_idRs;
  logic [REC_AW-1:0] w_idRt;
  logic [REC_AW-1:0] w_idDest;
  logic              w_stall;
  logic              w_loadInEx;

  assign w_idRs   = REC_AW'(id_rs);
  assign w_idRt   = REC_AW'(id_rt);
  assign w_idDest = id_reg_dst ? REC_AW'(id_rd) : REC_AW'(id_rt);

  assign w_loadInEx = r_exRec.valid & r_exRec.memRead & (r_exRec.dest != REG_ZERO);
  assign w_stall    = id_valid & ~flush & w_loadInEx &
                      ((r_exRec.dest == w_idRs) | (id_uses_rt & (r_exRec.dest == w_idRt)));

  fwd_sel u_fwdA (
    .srcValid (r_exRec.valid),
    .srcReg   (r_exRec.rs),
    .memRec   (r_memRec),
    .wbRec    (r_wbRec),
    .sel      (forward_a)
  );

  fwd_sel u_fwdB (
    .srcValid (r_exRec.valid),
    .srcReg   (r_exRec.rt),
    .memRec   (r_memRec),
    .wbRec    (r_wbRec),
    .sel      (forward_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exRec      <= '0;
      r_memRec     <= '0;
      r_wbRec      <= '0;
      r_stallCount <= '0;
    end else begin
      r_wbRec  <= r_memRec;
      r_memRec <= r_exRec;
      if (w_stall | flush | ~id_valid) begin
        r_exRec <= '0;
      end else begin
        r_exRec <= '{valid:    1'b1,
                     rs:       w_idRs,
                     rt:       w_idRt,
                     dest:     w_idDest,
                     regWrite: id_reg_write,
                     memRead:  id_mem_read};
      end
      if (w_stall && (r_stallCount != {CNT_W{1'b1}}))
        r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign stall       = w_stall;
  assign ex_bubble   = ~r_exRec.valid;
  assign stall_count = r_stallCount;

endmodule

`default_nettype wire

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Hazard and forwarding controller for the EX stage of the 5-stage pipeline. It keeps its own registered shadow of the destination register, write-enable and load flag for the instructions in EX, MEM and WB. From this it drives the 2-bit forwardA/forwardB selects of the EX operand muxes, detects load-use hazards, stalls IF/ID and injects bubbles into EX. It also keeps a saturating stall counter for performance analysis.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  ID source register 1.
- id_rt  in  REG_AW  ID source register 2 / I-type destination.
- id_rd  in  REG_AW  ID R-type destination.
- id_reg_dst  in  1  1 = destination is rd, 0 = destination is rt (same rule as the EX RegDst mux).
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- flush  in  1  squash the instruction currently in ID (taken branch/jump).
- forward_a  out  2  operand-A select: 00 = Data1, 01 = preData (EX/MEM), 10 = prePreData (MEM/WB).
- forward_b  out  2  operand-B select; same encoding as forward_a.
- stall  out  1  hold PC and the IF/ID register this cycle.
- ex_bubble  out  1  EX stage holds a bubble (registered).
- stall_count  out  CNT_W  number of cycles with stall asserted, saturating.

Behaviour:
- Shadow state is three stage records, EX, MEM and WB. Each record holds: valid, rs, rt, dest, reg_write, mem_read.
- dest is captured when the record enters EX: id_reg_dst ? id_rd : id_rt.
- Reset (rst_n=0 at a clock edge):
  - all records go invalid with zero fields;
  - stall_count = 0;
  - the next cycle shows forward_a = forward_b = 00, stall = 0, ex_bubble = 1.
- Pipeline advance, every clock edge with rst_n=1:
  - WB <= MEM, then MEM <= EX.
  - EX <= bubble if (stall | flush | !id_valid); otherwise EX <= ID fields with valid = 1.
  - MEM and WB always advance. The block never freezes the downstream stages.
- Forwarding is combinational from the registered EX/MEM/WB records, so it is valid for the whole EX cycle. For operand A (source = EX.rs):
  - 01 if MEM.valid & MEM.reg_write & !MEM.mem_read & MEM.dest != 0 & MEM.dest == EX.rs;
  - else 10 if WB.valid & WB.reg_write & WB.dest != 0 & WB.dest == EX.rs;
  - else 00.
  - MEM has priority over WB (the youngest producer wins).
  - A load sitting in MEM never selects 01. Its address value is not data, so selection falls through to the WB check.
- Operand B uses the identical rule on EX.rt. It is evaluated regardless of whether ALUSrc picks the immediate, because MemWriteData comes from the forwarded B value.
- If EX is a bubble, forward_a = forward_b = 00.
- Load-use stall is combinational. stall = id_valid & !flush & EX.valid & EX.mem_read & EX.dest != 0, AND (EX.dest == id_rs OR (id_uses_rt & EX.dest == id_rt)).
- Stall sequence:
  - a stall lasts exactly one cycle and inserts one bubble;
  - on the next cycle EX holds the bubble, so stall deasserts;
  - the consumer reaches EX two cycles after the load and forwards from WB (10).
- flush and stall in the same cycle: flush wins, stall = 0, and EX receives a bubble.
- Writes to register 0 are never forwarded and never cause a stall.
- stall_count increments by 1 on each edge where stall = 1 and holds at 2^CNT_W-1.
- ex_bubble = !EX.valid.
- No output depends combinationally on forward_* or on ALU results. There are no loops through the EX datapath.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_REG = 2'b00, FWD_PRE = 2'b01, FWD_PREPRE = 2'b10;
  - REG_ZERO = 5'd0;
  - a stage-record typedef {valid, rs, rt, dest, reg_write, mem_read}.
- One natural sub-module: fwd_sel. It is a combinational comparator that produces one 2-bit select from a source register and the MEM/WB records. It is instantiated twice, once for A and once for B.
- The stage registers, stall logic and counter stay in ex_hazard_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> forward_a = forward_b = 00, stall = 0, ex_bubble = 1, stall_count = 0.
- EX/MEM forward: `add r3,r1,r2` then `sub r4,r3,r5` back-to-back -> with sub in EX, forward_a = 01 and forward_b = 00.
- Load-use: `lw r6,0(r1)` then `add r7,r6,r6` -> stall = 1 for exactly 1 cycle; next cycle ex_bubble = 1; then with add in EX, forward_a = forward_b = 10; stall_count = 1.
- Priority and zero register:
  - `add r3,...`, `or r3,...`, `and r8,r3,r0` -> with and in EX, forward_a = 01 (the younger or wins) and forward_b = 00;
  - a writer to r0 followed by a reader of r0 -> always 00.
- flush coincident with a load-use condition -> stall = 0, EX gets a bubble, stall_count unchanged.
- Saturation and mid-run reset:
  - force repeated load-use stalls until stall_count reaches 0xFFFF -> it holds at 0xFFFF;
  - assert rst_n=0 while a stall is pending -> next cycle all records are invalid and stall_count = 0.
